// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler sharing one W-bit up-counter among N
// requesters. The winner's counter runs from 0 up to its requested terminal
// value, then completion is reported with a one-cycle done pulse.
//
// Ports:
//   clk      clock, all logic on rising edge
//   rst      synchronous active-high reset
//   req      per-requester request level, held until done or abort
//   req_len  terminal count of requester i at [i*W +: W]
//   gnt      one-hot grant (registered)
//   busy     high while in RUN or DONE (registered)
//   cnt_val  shared counter value (registered)
//   done     one-cycle completion pulse (registered)
//   done_id  ID of the last completed requester (registered, holds)
module cnt_sched #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_len,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [W-1:0]         cnt_val,
  output logic                 done,
  output logic [$clog2(N)-1:0] done_id
);

  localparam int unsigned IDW = $clog2(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q,   state_d;
  logic [IDW-1:0] ptr_q,     ptr_d;
  logic [IDW-1:0] id_q,      id_d;
  logic [W-1:0]   len_q,     len_d;
  logic [W-1:0]   cnt_q,     cnt_d;
  logic [N-1:0]   gnt_q,     gnt_d;
  logic           busy_q,    busy_d;
  logic           done_q,    done_d;
  logic [IDW-1:0] done_id_q, done_id_d;

  logic [IDW-1:0] win_id;
  logic [IDW-1:0] id_next;

  // First set request bit searching upward from p, wrapping modulo N.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDW-1:0] p);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic           hit;
    pick = '0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDW'((32'(p) + i) % N);
      if (!hit && r[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
    return pick;
  endfunction

  assign win_id  = rr_pick(req, ptr_q);
  // Pointer moves past the requester that just finished or aborted.
  assign id_next = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req) begin
          id_d    = win_id;
          // Terminal count is captured only here; later changes are ignored.
          len_d   = req_len[win_id*W +: W];
          cnt_d   = '0;
          gnt_d   = N'(1) << win_id;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks terminal count; no done is reported on abort.
        if (!req[id_q]) begin
          gnt_d   = '0;
          ptr_d   = id_next;
          state_d = ST_IDLE;
        end else if (cnt_q == len_q) begin
          gnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = id_q;
          ptr_d     = id_next;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign cnt_val = cnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;

  // Grant is one-hot or idle, and never coincides with completion.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_not_done: assert property (@(posedge clk) disable iff (rst) !(|gnt_q && done_q));

endmodule

// File: tb/tb_cnt_sched.sv
// Directed self-checking bench for cnt_sched (N=4, W=4). Inputs are driven
// and outputs observed on the falling edge.
module tb_cnt_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cnt_val;
  logic        done;
  logic [1:0]  done_id;

  int errors = 0;
  int checks = 0;

  logic [11:0] obs;
  logic [11:0] exp_v;

  cnt_sched #(.N(4), .W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_val (cnt_val),
    .done    (done),
    .done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {gnt, busy, cnt_val, done, done_id};

  // Pack expected output fields in the same order as obs.
  function automatic logic [11:0] pk(input logic [3:0] g, input logic b,
                                     input logic [3:0] c, input logic d,
                                     input logic [1:0] id);
    return {g, b, c, d, id};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; req_len = '0;
    @(negedge clk);
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset: got %h expected %h", obs, exp_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0100; req_len[2*4 +: 4] = 4'd3;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      exp_v = pk(4'b0100, 1'b1, 4'(k), 1'b0, 2'd0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL single run k=%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b1, 4'd3, 1'b1, 2'd2);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL single done: got %h expected %h", obs, exp_v);
    end
    req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd3, 1'b0, 2'd2);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL single idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] prev;
    logic [1:0] id;
    rst = 1'b1; req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL fair reset: got %h expected %h", obs, exp_v);
    end
    rst = 1'b0; req = 4'b1111; req_len = '0;
    prev = 2'd0;
    for (int i = 0; i < 5; i++) begin
      id = 2'(i % 4);
      @(negedge clk);
      exp_v = pk(4'b0001 << id, 1'b1, 4'd0, 1'b0, prev);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL fair gnt i=%0d: got %h expected %h", i, obs, exp_v);
      end
      @(negedge clk);
      exp_v = pk(4'b0000, 1'b1, 4'd0, 1'b1, id);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL fair done i=%0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 4) req = '0;
      @(negedge clk);
      exp_v = pk(4'b0000, 1'b0, 4'd0, 1'b0, id);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL fair idle i=%0d: got %h expected %h", i, obs, exp_v);
      end
      prev = id;
    end
  endtask

  task automatic test_len_max();
    req = 4'b1000; req_len[3*4 +: 4] = 4'd15;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      exp_v = pk(4'b1000, 1'b1, 4'(k), 1'b0, 2'd0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL len15 k=%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b1, 4'd15, 1'b1, 2'd3);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL len15 done: got %h expected %h", obs, exp_v);
    end
    req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd15, 1'b0, 2'd3);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL len15 no wrap: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_abort();
    req = 4'b0010; req_len[1*4 +: 4] = 4'd9; req_len[0*4 +: 4] = 4'd0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      exp_v = pk(4'b0010, 1'b1, 4'(k), 1'b0, 2'd3);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL abort run k=%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    req = 4'b0001;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd4, 1'b0, 2'd3);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL abort drop: got %h expected %h", obs, exp_v);
    end
    req = 4'b0011;
    @(negedge clk);
    exp_v = pk(4'b0001, 1'b1, 4'd0, 1'b0, 2'd3);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL abort regrant: got %h expected %h", obs, exp_v);
    end
    req = 4'b0001;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b1, 4'd0, 1'b1, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL abort next done: got %h expected %h", obs, exp_v);
    end
    req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL abort idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_len_change();
    req = 4'b0010; req_len[1*4 +: 4] = 4'd2;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      exp_v = pk(4'b0010, 1'b1, 4'(k), 1'b0, 2'd0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL lenchg run k=%0d: got %h expected %h", k, obs, exp_v);
      end
      req_len[1*4 +: 4] = 4'd7;
    end
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b1, 4'd2, 1'b1, 2'd1);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL lenchg done: got %h expected %h", obs, exp_v);
    end
    req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd2, 1'b0, 2'd1);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL lenchg idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    req = 4'b0001; req_len[0*4 +: 4] = 4'd5;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      exp_v = pk(4'b0001, 1'b1, 4'(k), 1'b0, 2'd1);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rstmid run k=%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL rstmid cleared: got %h expected %h", obs, exp_v);
    end
    rst = 1'b0;
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      exp_v = pk(4'b0001, 1'b1, 4'(k), 1'b0, 2'd0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rstmid restart k=%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    req = '0;
    @(negedge clk);
    exp_v = pk(4'b0000, 1'b0, 4'd1, 1'b0, 2'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL rstmid drop: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_len_max();
    test_abort();
    test_len_change();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
